// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the cpu data/address/rw bus and its memory responders.
package mem_bus_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 4;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // One latched bus request
    typedef struct packed {
        logic [WORD_W-1:0] address;
        logic              rw;
        logic [WORD_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM with registered read data (read-before-write).
module mem_array
    import mem_bus_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [WORD_W-1:0] mem [DEPTH];

    // Write port and registered read port share one address
    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory responder: target end of the cpu data/address/rw bus.
// Optional feature macro: MEM_WRITE_PROTECT_EN (rejects writes below PROTECT_TOP).
module mem_responder
    import mem_bus_pkg::*;
#(
    parameter int unsigned ADDR_W      = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned PROTECT_TOP = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic [WORD_W-1:0] address,
    input  logic              rw,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              ready,
    output logic              fault
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    mem_req_t          req_q, req_d;
    mem_req_t          cur_c, src_c;
    logic [ADDR_W-1:0] offset_c;
    logic              in_range_c, protect_c, fault_c;
    logic              access_c, we_c;
    logic [WORD_W-1:0] ram_rdata;
    logic [WORD_W-1:0] rdata_d;
    logic              ready_d, fault_d;

    // Zero-wait accesses use the live bus; all others use the latched request
    always_comb begin
        cur_c      = '{address: address, rw: rw, wdata: wdata};
        src_c      = (state_q == IDLE) ? cur_c : req_q;
        offset_c   = src_c.address[ADDR_W-1:0];
        in_range_c = (src_c.address >> ADDR_W) == (BASE_ADDR >> ADDR_W);
    end

`ifdef MEM_WRITE_PROTECT_EN
    // Low offsets are read-only
    always_comb begin
        protect_c = (src_c.rw == RW_WRITE) && (WORD_W'(offset_c) < PROTECT_TOP);
    end
`else
    logic unused_protect_top;
    assign unused_protect_top = ^PROTECT_TOP;

    // Every in-range offset is writable
    always_comb begin
        protect_c = 1'b0;
    end
`endif

    // Rejected accesses have no side effect
    always_comb begin
        fault_c = !in_range_c || protect_c;
        we_c    = access_c && !reset && !fault_c && (src_c.rw == RW_WRITE);
    end

    // Next-state, access strobe and next output values
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        access_c = 1'b0;
        ready_d  = 1'b0;
        fault_d  = 1'b0;
        rdata_d  = rdata;
        case (state_q)
            IDLE: begin
                if (req) begin
                    req_d = cur_c;
                    cnt_d = CNT_W'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        access_c = 1'b1;
                        state_d  = RESP;
                    end else begin
                        state_d  = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    access_c = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                ready_d = 1'b1;
                fault_d = fault_c;
                if (fault_c) begin
                    rdata_d = '0;
                end else if (req_q.rw == RW_READ) begin
                    rdata_d = ram_rdata;
                end else begin
                    rdata_d = req_q.wdata;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, request latch and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            rdata   <= '0;
            ready   <= 1'b0;
            fault   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdata   <= rdata_d;
            ready   <= ready_d;
            fault   <= fault_d;
        end
    end

    mem_array #(
        .ADDR_W (ADDR_W)
    ) u_mem_array (
        .clock (clock),
        .we    (we_c),
        .addr  (offset_c),
        .wdata (src_c.wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench: three responders with WAIT_STATES = 1, 3 and 0.
module tb_mem_responder;

    logic             clock;
    logic [2:0]       reset;
    logic [2:0]       req;
    logic [2:0]       rw;
    logic [2:0][31:0] address;
    logic [2:0][31:0] wdata;
    logic [2:0][31:0] rdata;
    logic [2:0]       ready;
    logic [2:0]       fault;

    int n_checks;
    int n_errors;

    function automatic int ws_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 3 : 0;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned WS = (g == 0) ? 1 : (g == 1) ? 3 : 0;
        mem_responder #(
            .ADDR_W      (10),
            .BASE_ADDR   (32'h0),
            .WAIT_STATES (WS),
            .PROTECT_TOP (16)
        ) u_dut (
            .clock   (clock),
            .reset   (reset[g]),
            .req     (req[g]),
            .address (address[g]),
            .rw      (rw[g]),
            .wdata   (wdata[g]),
            .rdata   (rdata[g]),
            .ready   (ready[g]),
            .fault   (fault[g])
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete access; inputs are scrambled right after accept
    task automatic do_access(input int d, input logic rw_i, input logic [31:0] a,
                             input logic [31:0] wd, input logic exp_fault,
                             input logic [31:0] exp_rdata, input string tag);
        int lat;
        bit seen;
        @(negedge clock);
        req[d] = 1'b1; rw[d] = rw_i; address[d] = a; wdata[d] = wd;
        @(posedge clock);
        #1;
        req[d] = 1'b0; rw[d] = ~rw_i; address[d] = $urandom; wdata[d] = ~wd;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
            seen = ready[d];
        end
        check({tag, " latency"}, 32'(lat), 32'(ws_of(d) + 1));
        check({tag, " fault"}, 32'(fault[d]), 32'(exp_fault));
        check({tag, " rdata"}, rdata[d], exp_rdata);
        @(posedge clock);
        #1;
        check({tag, " pulse width"}, 32'(ready[d]), 32'd0);
    endtask

    initial begin
        int pulses;
        n_checks = 0;
        n_errors = 0;
        reset    = 3'b111;
        req      = '0;
        rw       = '0;
        address  = '0;
        wdata    = '0;

        // Reset state held for three cycles
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            check("reset ready", 32'(ready[0]), 32'd0);
            check("reset fault", 32'(fault[0]), 32'd0);
            check("reset rdata", rdata[0], 32'd0);
        end
        @(negedge clock);
        reset = 3'b000;

        // Write then read back, one wait state
        do_access(0, 1'b0, 32'h20, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, "wr 0x20");
        do_access(0, 1'b1, 32'h20, 32'h0,        1'b0, 32'hDEADBEEF, "rd 0x20");

        // Out of range read and write leave the RAM alone
        do_access(0, 1'b0, 32'h0,   32'h11110000, 1'b0, 32'h11110000, "wr 0x0");
        do_access(0, 1'b1, 32'h400, 32'h0,        1'b1, 32'h0,        "rd oor");
        do_access(0, 1'b0, 32'h400, 32'h12345678, 1'b1, 32'h0,        "wr oor");
        do_access(0, 1'b1, 32'h0,   32'h0,        1'b0, 32'h11110000, "rd 0x0");

        // Reset in the second WAIT cycle aborts the write
        do_access(1, 1'b0, 32'h30, 32'h0BADF00D, 1'b0, 32'h0BADF00D, "ws3 wr 0x30");
        do_access(1, 1'b0, 32'h31, 32'h31313131, 1'b0, 32'h31313131, "ws3 wr 0x31");
        @(negedge clock);
        req[1] = 1'b1; rw[1] = 1'b0; address[1] = 32'h30; wdata[1] = 32'hA5A5A5A5;
        @(posedge clock);
        #1;
        req[1] = 1'b0;
        @(posedge clock);
        #1;
        reset[1] = 1'b1;
        @(posedge clock);
        #1;
        reset[1] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            #1;
            check("abort no ready", 32'(ready[1]), 32'd0);
        end
        do_access(1, 1'b1, 32'h30, 32'h0, 1'b0, 32'h0BADF00D, "ws3 rd after abort");

        // A request during WAIT is ignored
        @(negedge clock);
        req[1] = 1'b1; rw[1] = 1'b1; address[1] = 32'h30;
        @(posedge clock);
        @(negedge clock);
        rw[1] = 1'b0; address[1] = 32'h31; wdata[1] = 32'hFFFFFFFF;
        @(posedge clock);
        @(negedge clock);
        req[1] = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clock);
            #1;
            if (ready[1]) begin
                pulses++;
                check("busy rdata", rdata[1], 32'h0BADF00D);
            end
        end
        check("busy pulse count", 32'(pulses), 32'd1);
        do_access(1, 1'b1, 32'h31, 32'h0, 1'b0, 32'h31313131, "ws3 rd 0x31");

        // Zero wait states with req held: ready on every second cycle
        do_access(2, 1'b0, 32'h1, 32'h0000C0DE, 1'b0, 32'h0000C0DE, "ws0 wr 0x1");
        @(negedge clock);
        req[2] = 1'b1; rw[2] = 1'b1; address[2] = 32'h1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clock);
            #1;
            check("ws0 ready pattern", 32'(ready[2]), 32'(k % 2));
            if (ready[2]) begin
                check("ws0 stream rdata", rdata[2], 32'h0000C0DE);
            end
        end
        @(negedge clock);
        req[2] = 1'b0;
        repeat (2) @(posedge clock);

        // Write protection of the low offsets
`ifdef MEM_WRITE_PROTECT_EN
        do_access(0, 1'b0, 32'h05, 32'h55555555, 1'b1, 32'h0, "wr 0x05 protected");
`else
        do_access(0, 1'b0, 32'h05, 32'h55555555, 1'b0, 32'h55555555, "wr 0x05");
        do_access(0, 1'b1, 32'h05, 32'h0,        1'b0, 32'h55555555, "rd 0x05");
`endif
        do_access(0, 1'b0, 32'h10, 32'h10101010, 1'b0, 32'h10101010, "wr 0x10");
        do_access(0, 1'b1, 32'h10, 32'h0,        1'b0, 32'h10101010, "rd 0x10");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
